// File: rtl/mm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mm_mem_responder
// Brief    : Memory-side responder for the matrix-multiply engine. Holds the
//            dimension registers, operand matrices A/B and result matrix C,
//            serves engine reads combinationally, captures engine writes and
//            sequences the host load / run / readback flow.
// Revision : 1.0 - initial release
// ============================================================================
module mm_mem_responder #(
  parameter int DW  = 20,
  parameter int MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  // host load port
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [1:0]      ld_sel,
  input  logic [DW-1:0]   ld_row,
  input  logic [DW-1:0]   ld_col,
  input  logic [DW-1:0]   ld_data,
  input  logic            start,
  input  logic            clear,
  // engine bus
  output logic            mm_rst,
  input  logic [DW-1:0]   i,
  input  logic [DW-1:0]   j,
  input  logic            index,
  input  logic            read,
  input  logic            write,
  input  logic [2*DW-1:0] write_data,
  input  logic            finish,
  output logic [DW-1:0]   read_data,
  // host readback and status
  input  logic [DW-1:0]   rd_row,
  input  logic [DW-1:0]   rd_col,
  output logic [2*DW-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   wr_count,
  output logic            addr_err,
  output logic            cfg_err
);

  localparam int            NE     = MAX * MAX;
  localparam int            AW     = $clog2(NE);
  localparam logic [DW-1:0] C_MAX  = DW'(MAX);
  localparam logic [DW-1:0] C_NDIM = DW'(3);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   wr_count_q, wr_count_d;
  logic            addr_err_q, addr_err_d;
  logic            cfg_err_q, cfg_err_d;
  logic [DW-1:0]   dims_q [3];

  // Storage is flattened row-major at i*MAX+j; contents survive reset.
  logic [DW-1:0]   mem_a [NE];
  logic [DW-1:0]   mem_b [NE];
  logic [2*DW-1:0] mem_c [NE];

  logic          w_eng_in_range, w_ld_in_range, w_rd_in_range;
  logic [AW-1:0] w_eng_idx, w_ld_idx, w_rd_idx;
  logic          w_ld_fire, w_dims_ok, w_run, w_eng_rd, w_eng_wr, w_c_wr;

  assign w_eng_in_range = (i < C_MAX) && (j < C_MAX);
  assign w_ld_in_range  = (ld_row < C_MAX) && (ld_col < C_MAX);
  assign w_rd_in_range  = (rd_row < C_MAX) && (rd_col < C_MAX);
  assign w_eng_idx      = AW'(i * C_MAX + j);
  assign w_ld_idx       = AW'(ld_row * C_MAX + ld_col);
  assign w_rd_idx       = AW'(rd_row * C_MAX + rd_col);

  assign w_run     = (state_q == ST_RUN);
  assign w_ld_fire = ld_valid && (state_q == ST_LOAD);
  assign w_eng_rd  = read && !write;
  assign w_eng_wr  = !read && write;
  // Out-of-range writes are dropped so they can never alias a real entry.
  assign w_c_wr    = w_run && w_eng_wr && w_eng_in_range;

  // Every dimension must lie in 1..MAX; checked against the pre-load values.
  assign w_dims_ok = (dims_q[0] != '0) && (dims_q[0] <= C_MAX) &&
                     (dims_q[1] != '0) && (dims_q[1] <= C_MAX) &&
                     (dims_q[2] != '0) && (dims_q[2] <= C_MAX);

  // State and status registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      wr_count_q <= '0;
      addr_err_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      addr_err_q <= addr_err_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Dimension registers, loaded by the host with ld_sel==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) dims_q[k] <= '0;
    end else if (w_ld_fire && (ld_sel == 2'd0) && (ld_row < C_NDIM)) begin
      dims_q[ld_row[1:0]] <= ld_data;
    end
  end

  // Matrix storage writes: host loads A/B, engine writes C.
  always_ff @(posedge clk) begin
    if (w_ld_fire && (ld_sel == 2'd1) && w_ld_in_range) mem_a[w_ld_idx] <= ld_data;
    if (w_ld_fire && (ld_sel == 2'd2) && w_ld_in_range) mem_b[w_ld_idx] <= ld_data;
    if (w_c_wr) mem_c[w_eng_idx] <= write_data;
  end

  // Next-state, counter/flag updates and Moore outputs.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    addr_err_d = addr_err_q;
    cfg_err_d  = cfg_err_q;
    mm_rst     = 1'b1;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (start) begin
          if (w_dims_ok) begin
            state_d    = ST_RUN;
            wr_count_d = '0;
            addr_err_d = 1'b0;
            cfg_err_d  = 1'b0;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        mm_rst = 1'b0;
        busy   = 1'b1;
        if (w_c_wr && (wr_count_q != '1)) wr_count_d = wr_count_q + 1'b1;
        // Dimension-phase reads (read&&write) use i only and are excluded.
        if ((w_eng_rd || w_eng_wr) && !w_eng_in_range) addr_err_d = 1'b1;
        if (finish) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (clear) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Engine read data, valid in the same cycle as the address.
  always_comb begin
    read_data = '0;
    if (read && write) begin
      if (i < C_NDIM) read_data = dims_q[i[1:0]];
    end else if (read && w_eng_in_range) begin
      read_data = index ? mem_b[w_eng_idx] : mem_a[w_eng_idx];
    end
  end

  // Host readback of C, zero outside the matrix bounds.
  always_comb begin
    rd_data = '0;
    if (w_rd_in_range) rd_data = mem_c[w_rd_idx];
  end

  assign wr_count = wr_count_q;
  assign addr_err = addr_err_q;
  assign cfg_err  = cfg_err_q;

endmodule
`default_nettype wire
